rails_stack_chk: RTL

RAILS_STACK_CHK -- requirements
Module: rails_stack_chk

---
 rtl/rails_pkg.sv | 29 ++
 rtl/rails_lifo.sv | 61 ++++++
 rtl/rails_stack_chk.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rails_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rails_pkg
//  Description : Shared types and constants for the rails stack checker:
//                FSM state encoding, verdict fail codes and the default
//                geometry of the checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package rails_pkg;

    localparam int c_def_w     = 4;
    localparam int c_def_max_n = 15;
    localparam int c_def_depth = 8;

    localparam logic [1:0] c_fc_ok       = 2'd0;
    localparam logic [1:0] c_fc_order    = 2'd1;
    localparam logic [1:0] c_fc_overflow = 2'd2;
    localparam logic [1:0] c_fc_badarg   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_EVAL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rails_lifo.sv
`default_nettype none
// ============================================================================
//  Module      : rails_lifo
//  Description : Station stack holding car IDs. The top entry is presented
//                combinationally; push is ignored when full, pop when empty.
//                clear (or reset) empties the stack in one cycle.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                clear             - empty the stack
//                push / din        - push din onto the stack
//                pop               - discard the top entry
//                top               - current top entry (undefined when empty)
//                full / empty      - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module rails_lifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);

    logic [W-1:0]    r_mem [0:DEPTH-1];
    logic [c_cw-1:0] r_count;
    logic [c_aw-1:0] w_top_idx;

    assign full      = (r_count == c_cw'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_top_idx = c_aw'(r_count - 1'b1);
    assign top       = r_mem[w_top_idx];

    // The owner never pushes and pops in the same cycle, so push simply
    // takes precedence here.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + 1'b1;
        end else if (pop && !empty) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear && !reset) begin
            r_mem[c_aw'(r_count)] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rails_stack_chk.sv
`default_nettype none
// ============================================================================
//  Module      : rails_stack_chk
//  Description : On-the-fly checker for the "rails" station problem. Cars
//                1..N arrive in order; each beat names the next car that must
//                leave. The checker pushes arriving cars onto the station
//                stack until the wanted car is on top, then pops it. One
//                verdict strobe is issued per train.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                start, number         - strobe loading train length N
//                in_valid, in_ready, data - departure-order beat handshake
//                out_valid             - one-cycle verdict strobe
//                result                - 1 when the order is achievable
//                fail_code             - 0 OK, 1 ORDER, 2 OVERFLOW, 3 BADARG
//  Revision    : 1.0 - initial release
// ============================================================================
module rails_stack_chk
    import rails_pkg::*;
#(
    parameter int W     = c_def_w,
    parameter int MAX_N = c_def_max_n,
    parameter int DEPTH = c_def_depth
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] number,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data,
    output logic         out_valid,
    output logic         result,
    output logic [1:0]   fail_code
);

    localparam logic [W:0] c_max_n = (W+1)'(MAX_N);

    state_t       r_state;
    state_t       w_next_state;

    // W+1 bits so next_in can reach N+1 without wrapping.
    logic [W:0]   r_next_in;
    logic [W:0]   r_cnt;
    logic [W:0]   r_beats;
    logic [W:0]   r_n;
    logic [W-1:0] r_tgt;
    logic [1:0]   r_code;
    logic         r_out_valid;
    logic         r_result;
    logic [1:0]   r_fail_code;

    logic         w_accept;
    logic         w_start_bad;
    logic         w_data_bad;
    logic         w_last_beat;
    logic         w_hit;
    logic         w_can_push;
    logic         w_push;
    logic         w_pop;
    logic         w_clear;
    logic         w_err_set;
    logic [1:0]   w_err_code;
    logic [1:0]   w_final_code;

    logic [W-1:0] w_top;
    logic         w_full;
    logic         w_empty;

    rails_lifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_next_in[W-1:0]),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_accept    = in_valid && in_ready;
    assign w_start_bad = (number == '0) || ({1'b0, number} > c_max_n);
    assign w_data_bad  = (data == '0) || ({1'b0, data} > r_n);
    // r_beats counts beats accepted before the one currently offered.
    assign w_last_beat = ((r_beats + 1'b1) == r_n);
    assign w_hit       = !w_empty && (w_top == r_tgt);
    assign w_can_push  = (r_next_in <= {1'b0, r_tgt});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_start_bad ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_accept) begin
                    if (w_data_bad) begin
                        w_next_state = w_last_beat ? S_DONE : S_DRAIN;
                    end else begin
                        w_next_state = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                // A failure on the final beat has nothing left to drain.
                if (w_hit) begin
                    w_next_state = ((r_cnt + 1'b1) == r_n) ? S_DONE : S_WAIT;
                end else if (w_can_push && !w_full) begin
                    w_next_state = S_EVAL;
                end else begin
                    w_next_state = (r_beats == r_n) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_accept && w_last_beat) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clear    = 1'b0;
        w_err_set  = 1'b0;
        w_err_code = c_fc_ok;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear    = !w_start_bad;
                    w_err_set  = w_start_bad;
                    w_err_code = c_fc_badarg;
                end
            end
            S_WAIT: begin
                in_ready   = 1'b1;
                w_err_set  = w_accept && w_data_bad;
                w_err_code = c_fc_badarg;
            end
            S_EVAL: begin
                if (w_hit) begin
                    w_pop = 1'b1;
                end else if (w_can_push) begin
                    w_push     = !w_full;
                    w_err_set  = w_full;
                    w_err_code = c_fc_overflow;
                end else begin
                    w_err_set  = 1'b1;
                    w_err_code = c_fc_order;
                end
            end
            S_DRAIN: in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Errors are only raised outside DRAIN, where the code is still OK,
    // so the first failure is the one that survives to the verdict.
    assign w_final_code = w_err_set ? w_err_code : r_code;

    // ------------------------------------------------------------------
    // Counters and verdict registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_in   <= '0;
            r_cnt       <= '0;
            r_beats     <= '0;
            r_n         <= '0;
            r_tgt       <= '0;
            r_code      <= c_fc_ok;
            r_out_valid <= 1'b0;
            r_result    <= 1'b0;
            r_fail_code <= c_fc_ok;
        end else begin
            if (w_clear) begin
                r_next_in <= (W+1)'(1);
                r_cnt     <= '0;
                r_beats   <= '0;
                r_n       <= {1'b0, number};
                r_code    <= c_fc_ok;
            end
            if (w_err_set) begin
                r_code <= w_err_code;
            end
            if (w_accept) begin
                r_beats <= r_beats + 1'b1;
                if (r_state == S_WAIT) begin
                    r_tgt <= data;
                end
            end
            if (w_push) begin
                r_next_in <= r_next_in + 1'b1;
            end
            if (w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_out_valid <= (w_next_state == S_DONE);
            if (w_next_state == S_DONE) begin
                r_fail_code <= w_final_code;
                r_result    <= (w_final_code == c_fc_ok);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign fail_code = r_fail_code;

endmodule
`default_nettype wire
